// File: rtl/out_channel_drain_if.sv
// Word bus between the interpreter, the out-channel drain and the host link.
// The drain uses the slave modport; the interpreter/host side uses master.
interface out_channel_drain_if #(
  parameter int W = 12
);
  logic         out_write;
  logic [W-1:0] out_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [W-1:0] tx_data;
  logic         tx_last;

  modport master (
    output out_write, out_data, tx_ready,
    input  tx_valid, tx_data, tx_last
  );

  modport slave (
    input  out_write, out_data, tx_ready,
    output tx_valid, tx_data, tx_last
  );
endinterface

// File: rtl/out_channel_drain.sv
// Buffers out-channel words in a FIFO, streams them to the host, then sends a status trailer.
// Optional macro OUT_CHANNEL_PARITY_EN adds a registered tx_parity output covering tx_data.
module out_channel_drain #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 16
) (
  input  logic               clock,
  input  logic               reset,
  out_channel_drain_if.slave bus,
  input  logic               finished,
  input  logic               success,
  output logic               overflow,
  output logic               done
`ifdef OUT_CHANNEL_PARITY_EN
  ,
  output logic               tx_parity
`endif
);

  localparam int W  = MemoryElementWidth;
  localparam int AW = $clog2(NOut);
  localparam int CW = W - 2;
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_ZERO = '0;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(NOut);

  typedef enum logic [1:0] {STREAM, TRAILER, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  mem_q [NOut];
  logic [W-1:0]  mem_d [NOut];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] sent_q, sent_d;
  logic          finish_q, finish_d;
  logic          success_l_q, success_l_d;
  logic          overflow_q, overflow_d;
  logic          done_q, done_d;
  logic          tx_valid_q, tx_valid_d;
  logic          tx_last_q, tx_last_d;
  logic [W-1:0]  tx_data_q, tx_data_d;

  logic [AW:0]   cnt;
  logic [AW-1:0] head_idx;
  logic          accept, slot_free, full, push, drop, avail;
  logic          latch_eff, success_eff;

  // The presented word stays in the FIFO until the host accepts it, so it counts toward capacity.
  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    sent_d      = sent_q;
    overflow_d  = overflow_q;
    done_d      = done_q;
    tx_valid_d  = tx_valid_q;
    tx_last_d   = tx_last_q;
    tx_data_d   = tx_data_q;

    cnt         = wr_ptr_q - rd_ptr_q;
    accept      = (state_q == STREAM) && tx_valid_q && bus.tx_ready;
    slot_free   = !tx_valid_q || bus.tx_ready;
    full        = (cnt == CNT_FULL);
    push        = bus.out_write && !finish_q && (!full || accept);
    drop        = bus.out_write && !finish_q && full && !accept;
    latch_eff   = finish_q || finished;
    success_eff = finish_q ? success_l_q : success;
    finish_d    = latch_eff;
    success_l_d = success_eff;
    head_idx    = accept ? rd_ptr_q[AW-1:0] + AW'(1) : rd_ptr_q[AW-1:0];
    avail       = accept ? (cnt > PTR_ONE) : (cnt != CNT_ZERO);

    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = bus.out_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
    if (accept) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      sent_d   = sent_q + CW'(1);
    end

    case (state_q)
      STREAM: begin
        if (slot_free) begin
          if (avail) begin
            tx_valid_d = 1'b1;
            tx_last_d  = 1'b0;
            tx_data_d  = mem_q[head_idx];
          end else if (latch_eff && !push) begin
            state_d    = TRAILER;
            tx_valid_d = 1'b1;
            tx_last_d  = 1'b1;
            tx_data_d  = {success_eff, overflow_q, sent_d};
          end else begin
            tx_valid_d = 1'b0;
          end
        end
      end
      TRAILER: begin
        if (bus.tx_ready) begin
          state_d    = DONE;
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          done_d     = 1'b1;
        end
      end
      DONE: begin
      end
      default: begin
        state_d = STREAM;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= STREAM;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      sent_q      <= '0;
      finish_q    <= 1'b0;
      success_l_q <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      sent_q      <= sent_d;
      finish_q    <= finish_d;
      success_l_q <= success_l_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      tx_valid_q  <= tx_valid_d;
      tx_last_q   <= tx_last_d;
      tx_data_q   <= tx_data_d;
    end
  end

`ifdef OUT_CHANNEL_PARITY_EN
  logic tx_parity_q, tx_parity_d;

  always_comb begin
    tx_parity_d = ^tx_data_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_parity_q <= 1'b0;
    end else begin
      tx_parity_q <= tx_parity_d;
    end
  end

  assign tx_parity = tx_parity_q;
`endif

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_last  = tx_last_q;
  assign overflow     = overflow_q;
  assign done         = done_q;

endmodule

// File: tb/tb_out_channel_drain.sv
// Bench for out_channel_drain: scenario table, hand-written corner sequences and
// randomized traffic checked by a queue-based model of the out channel.
module tb_out_channel_drain;

  localparam int W    = 12;
  localparam int NOut = 16;
  localparam int CW   = W - 2;

  logic clock = 1'b0;
  logic reset;
  logic finished;
  logic success;
  logic overflow;
  logic done;
`ifdef OUT_CHANNEL_PARITY_EN
  logic tx_parity;
`endif

  out_channel_drain_if #(.W(W)) bus();

  out_channel_drain #(.MemoryElementWidth(W), .NOut(NOut)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .finished (finished),
    .success  (success),
    .overflow (overflow),
    .done     (done)
`ifdef OUT_CHANNEL_PARITY_EN
    ,
    .tx_parity(tx_parity)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  // Model: words written but not yet taken by the host, plus the status the trailer must report.
  logic [W-1:0] pend[$];
  logic [W-1:0] got[$];
  bit           m_latched, m_succ, m_ovf, m_done;
  int           m_sent;
  logic [W-1:0] m_trailer;

  typedef struct {
    int           n;
    int           first;
    int           stride;
    int           stall;
    bit           succ;
    int           exp_sent;
    logic [W-1:0] exp_trailer;
    bit           exp_ovf;
  } row_t;

  row_t rows[5];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
  endtask

  task automatic failNow(input string name);
    checks++;
    $display("[TB] FAIL %s: condition not met", name);
  endtask

  task automatic modelReset();
    pend.delete();
    got.delete();
    m_latched = 0;
    m_succ    = 0;
    m_ovf     = 0;
    m_done    = 0;
    m_sent    = 0;
    m_trailer = '0;
  endtask

  task automatic step();
    bit           pv, pl, rdy;
    logic [W-1:0] pd;
    pv  = bus.tx_valid;
    pl  = bus.tx_last;
    pd  = bus.tx_data;
    rdy = bus.tx_ready;
    if (reset) begin
      modelReset();
    end else begin
      if (pv && rdy) begin
        if (pl) begin
          m_trailer = pd;
          checkOutput("trailer word", pd, {20'd0, m_succ, m_ovf, m_sent[CW-1:0]});
          m_done = 1;
        end else if (pend.size() == 0) begin
          failNow("unexpected data word");
        end else begin
          checkOutput("stream word", pd, pend.pop_front());
          got.push_back(pd);
          m_sent++;
        end
      end
      if (bus.out_write && !m_latched) begin
        if (pend.size() < NOut) pend.push_back(bus.out_data);
        else m_ovf = 1;
      end
      if (finished && !m_latched) begin
        m_latched = 1;
        m_succ    = success;
      end
    end
    @(posedge clock);
    #1;
    if (!reset) begin
      checkOutput("overflow flag", overflow, m_ovf);
      checkOutput("done flag", done, m_done);
      if (pv && !rdy) begin
        checkOutput("held valid", bus.tx_valid, 1);
        checkOutput("held data", bus.tx_data, pd);
        checkOutput("held last", bus.tx_last, pl);
      end
      if (bus.tx_valid && bus.tx_last && !(pend.size() == 0 && m_latched))
        failNow("trailer before stream drained");
      if (m_done && bus.tx_valid) failNow("valid after done");
`ifdef OUT_CHANNEL_PARITY_EN
      checkOutput("parity", tx_parity, ^bus.tx_data);
`endif
    end
  endtask

  task automatic applyStimulus(input bit wr, input logic [W-1:0] data, input bit fin,
                               input bit succ, input bit rdy);
    bus.out_write = wr;
    bus.out_data  = data;
    finished      = fin;
    success       = succ;
    bus.tx_ready  = rdy;
    step();
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(0, '0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while (!m_done && k < budget) begin
      applyStimulus(0, '0, 0, 0, 1);
      k++;
    end
    if (!m_done) failNow(tag);
  endtask

  task automatic runRow(input int idx, input row_t r);
    doReset();
    for (int i = 0; i < r.n; i++) applyStimulus(1, W'(r.first + i * r.stride), 0, 0, 0);
    for (int s = 0; s < r.stall; s++) applyStimulus(0, '0, 0, 0, 0);
    if (r.n > 0 && r.stall > 0) begin
      checkOutput($sformatf("row%0d stalled valid", idx), bus.tx_valid, 1);
      checkOutput($sformatf("row%0d stalled head", idx), bus.tx_data, W'(r.first));
    end
    applyStimulus(0, '0, 1, r.succ, 1);
    drain($sformatf("row%0d drain timeout", idx), 100);
    checkOutput($sformatf("row%0d words sent", idx), got.size(), r.exp_sent);
    for (int k = 0; k < got.size(); k++)
      checkOutput($sformatf("row%0d word %0d", idx, k), got[k], W'(r.first + k * r.stride));
    checkOutput($sformatf("row%0d trailer", idx), m_trailer, r.exp_trailer);
    checkOutput($sformatf("row%0d overflow", idx), overflow, r.exp_ovf);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int wr_pct, rdy_pct, len;

    rows[0] = '{2,  3, 2, 0,  1'b1, 2,  12'h802, 1'b0};
    rows[1] = '{2,  3, 2, 10, 1'b1, 2,  12'h802, 1'b0};
    rows[2] = '{18, 0, 1, 0,  1'b0, 16, 12'h410, 1'b1};
    rows[3] = '{0,  0, 1, 0,  1'b1, 0,  12'h800, 1'b0};
    rows[4] = '{16, 0, 1, 0,  1'b1, 16, 12'h810, 1'b0};

    reset         = 1'b1;
    bus.out_write = 1'b0;
    bus.out_data  = '0;
    bus.tx_ready  = 1'b0;
    finished      = 1'b0;
    success       = 1'b0;
    modelReset();

    doReset();
    checkOutput("reset tx_valid", bus.tx_valid, 0);
    checkOutput("reset tx_data", bus.tx_data, 0);
    checkOutput("reset tx_last", bus.tx_last, 0);
    checkOutput("reset overflow", overflow, 0);
    checkOutput("reset done", done, 0);
`ifdef OUT_CHANNEL_PARITY_EN
    checkOutput("reset parity", tx_parity, 0);
`endif

    for (int i = 0; i < 5; i++) runRow(i, rows[i]);

    // Finish with an empty FIFO: trailer on the very next cycle.
    doReset();
    applyStimulus(0, '0, 1, 1, 0);
    checkOutput("empty finish valid", bus.tx_valid, 1);
    checkOutput("empty finish last", bus.tx_last, 1);
    checkOutput("empty finish data", bus.tx_data, 12'h800);
    applyStimulus(0, '0, 0, 0, 1);
    checkOutput("empty finish done", done, 1);
    checkOutput("empty finish idle", bus.tx_valid, 0);

    // Write alongside finish is kept; the following write is ignored.
    doReset();
    applyStimulus(1, 12'd7, 1, 1, 1);
    applyStimulus(1, 12'd9, 0, 0, 1);
    drain("late write drain timeout", 50);
    checkOutput("late write count", got.size(), 1);
    if (got.size() > 0) checkOutput("late write word", got[0], 7);
    checkOutput("late write trailer", m_trailer, 12'h801);
    checkOutput("late write overflow", overflow, 0);

    // Reset in the middle of a stream.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, W'(10 + i), 0, 0, 0);
    k = 0;
    while (got.size() < 2 && k < 50) begin
      applyStimulus(0, '0, 0, 0, 1);
      k++;
    end
    checkOutput("mid reset words before", got.size(), 2);
    reset = 1'b1;
    applyStimulus(0, '0, 0, 0, 1);
    checkOutput("mid reset valid", bus.tx_valid, 0);
    checkOutput("mid reset done", done, 0);
    checkOutput("mid reset overflow", overflow, 0);
    reset = 1'b0;
    applyStimulus(1, 12'd4, 0, 0, 1);
    applyStimulus(0, '0, 1, 1, 1);
    drain("after reset drain timeout", 50);
    checkOutput("after reset count", got.size(), 1);
    if (got.size() > 0) checkOutput("after reset word", got[0], 4);
    checkOutput("after reset trailer", m_trailer, 12'h801);

    // Random traffic; the last run is long enough to wrap the sent count.
    for (int r = 0; r < 8; r++) begin
      doReset();
      wr_pct  = $urandom_range(30, 100);
      rdy_pct = $urandom_range(20, 100);
      len     = $urandom_range(20, 80);
      if (r == 7) begin
        wr_pct  = 100;
        rdy_pct = 100;
        len     = 1100;
      end
      for (int c = 0; c < len; c++)
        applyStimulus($urandom_range(0, 99) < wr_pct, W'($urandom), 0, 0,
                      $urandom_range(0, 99) < rdy_pct);
      applyStimulus($urandom_range(0, 99) < wr_pct, W'($urandom), 1, 1'($urandom),
                    $urandom_range(0, 99) < rdy_pct);
      k = 0;
      while (!m_done && k < 1000) begin
        applyStimulus($urandom_range(0, 1) == 1, W'($urandom), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 99) < rdy_pct);
        k++;
      end
      if (!m_done) failNow($sformatf("random run %0d drain timeout", r));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
